// File: rtl/fwd_ctrl_pkg.sv
// Shared types for the forwarding/hazard controller: select codes,
// the per-stage history entry and the producer test used by every stage.
package fwd_ctrl_pkg;

    // Width of the destination index held in each stage entry
    localparam int RD_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            load;
    } stage_t;

    // An entry only produces a forwardable value if it really writes a
    // non-zero register; bubbles and x0 writers never match anything.
    function automatic logic is_producer(stage_t e);
        return e.valid && e.we && (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Computes the forwarding select for one D-stage source operand from the
// X and M history entries. Pure combinational; instantiated per source.
module fwd_sel_calc
    import fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = RD_W
) (
    input  logic [REG_AW-1:0] src,
    input  stage_t            x_ent,
    input  stage_t            m_ent,
    output logic [1:0]        sel
);

    // A load result is already in W by the time it reaches the consumer,
    // so the M entry's load flag never changes the selected path.
    logic unused_m_load;
    assign unused_m_load = m_ent.load;

    // Youngest producer wins: a non-load X match beats any M match; x0 never forwards
    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (is_producer(x_ent) && (x_ent.rd == src) && !x_ent.load) begin
                sel = FWD_MEM;
            end else if (is_producer(m_ent) && (m_ent.rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the D -> X -> M -> W
// integer pipeline. Tracks destination history of in-flight instructions,
// registers the X-stage operand mux selects and stalls D/F on load-use.
module fwd_ctrl
    import fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = RD_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              ld_stall,
    output logic [CNT_W-1:0]  ld_stall_cnt
);

    stage_t x_q;
    stage_t m_q;
    // W history is tracked for completeness of the pipeline picture; the
    // regfile is write-first so nothing in D ever needs to compare against it.
    stage_t w_unused_q;
    stage_t d_ent;

    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // Pack the D-stage instruction into the same shape as the history entries
    always_comb begin
        d_ent       = '0;
        d_ent.valid = id_valid;
        d_ent.rd    = id_rd;
        d_ent.we    = id_we;
        d_ent.load  = id_is_load;
    end

    fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_a (
        .src   (id_rs1),
        .x_ent (x_q),
        .m_ent (m_q),
        .sel   (sel_a)
    );

    fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_b (
        .src   (id_rs2),
        .x_ent (x_q),
        .m_ent (m_q),
        .sel   (sel_b)
    );

    // Load in X feeding either D source: its data only exists after M, so hold D one cycle.
    // Both sources are checked regardless of use; a rare false stall is cheaper than decode.
    always_comb begin
        ld_stall = id_valid && !flush && is_producer(x_q) && x_q.load &&
                   ((x_q.rd == id_rs1) || (x_q.rd == id_rs2));
    end

    // Advance the history and selects; hold freezes everything, flush kills D and X,
    // a stall injects a bubble into X while the producer moves on to M.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            m_q          <= '0;
            w_unused_q   <= '0;
            fwd_a_sel    <= FWD_RF;
            fwd_b_sel    <= FWD_RF;
            ld_stall_cnt <= '0;
        end else if (!hold) begin
            w_unused_q <= m_q;
            if (flush) begin
                x_q       <= '0;
                m_q       <= '0;
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
            end else if (ld_stall) begin
                x_q          <= '0;
                m_q          <= x_q;
                fwd_a_sel    <= FWD_RF;
                fwd_b_sel    <= FWD_RF;
                ld_stall_cnt <= ld_stall_cnt + 1'b1;
            end else begin
                x_q       <= d_ent;
                m_q       <= x_q;
                fwd_a_sel <= sel_a;
                fwd_b_sel <= sel_b;
            end
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed scenarios for the key hazard
// cases followed by randomized traffic, all checked against an
// instruction-level model of which older instruction supplies each operand.
module tb_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        id_is_load;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        ld_stall;
    logic [31:0] ld_stall_cnt;

    fwd_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_we        (id_we),
        .id_is_load   (id_is_load),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .ld_stall     (ld_stall),
        .ld_stall_cnt (ld_stall_cnt)
    );

    always #5 clk = ~clk;

    // One in-flight instruction as the model sees it
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } ins_t;

    // older[0] = instruction one slot ahead of D, older[1] = two slots ahead
    ins_t        older [2];
    bit [1:0]    exp_a;
    bit [1:0]    exp_b;
    bit [31:0]   exp_cnt;
    bit          model_known;
    bit          seen_stall;
    int          num_checks;
    int          num_fails;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit writes(ins_t i, bit [4:0] r);
        return i.v && i.we && (i.rd != 5'd0) && (i.rd == r);
    endfunction

    // Youngest older writer decides: a non-load one slot ahead is in M next cycle (01),
    // a writer two slots ahead is in W next cycle (10).
    function automatic bit [1:0] want_sel(bit [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (writes(older[0], r) && !older[0].ld) return 2'b01;
        if (writes(older[1], r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit want_stall(bit v, bit f, bit [4:0] s1, bit [4:0] s2);
        return v && !f && older[0].ld && (writes(older[0], s1) || writes(older[0], s2));
    endfunction

    // Drive one cycle of D-stage inputs, check the stall before the edge and
    // the registered outputs after it, advancing the model alongside.
    task automatic applyStimulus(input bit r, input bit h, input bit f, input bit v,
                                 input bit [4:0] s1, input bit [4:0] s2, input bit [4:0] d,
                                 input bit w, input bit l);
        bit   exp_stall;
        ins_t dins;
        ins_t bubble;
        @(negedge clk);
        rst = r; hold = h; flush = f; id_valid = v;
        id_rs1 = s1; id_rs2 = s2; id_rd = d; id_we = w; id_is_load = l;
        exp_stall = want_stall(v, f, s1, s2);
        #1;
        seen_stall = ld_stall;
        if (model_known) checkOutput("ld_stall", {31'd0, ld_stall}, {31'd0, exp_stall});
        @(posedge clk);
        bubble = '{v: 1'b0, rd: 5'd0, we: 1'b0, ld: 1'b0};
        dins   = '{v: v, rd: d, we: w, ld: l};
        if (r) begin
            older[0] = bubble; older[1] = bubble;
            exp_a = 2'b00; exp_b = 2'b00; exp_cnt = 32'd0;
            model_known = 1'b1;
        end else if (!h) begin
            if (f) begin
                older[0] = bubble; older[1] = bubble;
                exp_a = 2'b00; exp_b = 2'b00;
            end else if (exp_stall) begin
                older[1] = older[0]; older[0] = bubble;
                exp_a = 2'b00; exp_b = 2'b00;
                exp_cnt = exp_cnt + 32'd1;
            end else begin
                exp_a = want_sel(s1); exp_b = want_sel(s2);
                older[1] = older[0]; older[0] = dins;
            end
        end
        #1;
        if (model_known) begin
            checkOutput("fwd_a_sel", {30'd0, fwd_a_sel}, {30'd0, exp_a});
            checkOutput("fwd_b_sel", {30'd0, fwd_b_sel}, {30'd0, exp_b});
            checkOutput("ld_stall_cnt", ld_stall_cnt, exp_cnt);
        end
    endtask

    task automatic nop();
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        num_checks = 0; num_fails = 0; model_known = 1'b0;
        rst = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_we = 1'b0; id_is_load = 1'b0;

        // Reset held two cycles
        applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        checkOutput("rst_a", {30'd0, fwd_a_sel}, 32'd0);
        checkOutput("rst_b", {30'd0, fwd_b_sel}, 32'd0);
        checkOutput("rst_stall", {31'd0, ld_stall}, 32'd0);
        checkOutput("rst_cnt", ld_stall_cnt, 32'd0);

        // Load-use: lw x3 ; add rs2=x3 -> one stall, then select 10
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd3, 1, 1);
        applyStimulus(0, 0, 0, 1, 5'd1, 5'd3, 5'd6, 1, 0);
        checkOutput("lu_stall_on", {31'd0, seen_stall}, 32'd1);
        checkOutput("lu_bubble_b", {30'd0, fwd_b_sel}, 32'd0);
        applyStimulus(0, 0, 0, 1, 5'd1, 5'd3, 5'd6, 1, 0);
        checkOutput("lu_stall_off", {31'd0, seen_stall}, 32'd0);
        checkOutput("lu_b_wb", {30'd0, fwd_b_sel}, 32'd2);
        checkOutput("lu_cnt", ld_stall_cnt, 32'd1);
        nop(); nop();

        // ALU back-to-back -> 01
        applyStimulus(0, 0, 0, 1, 5'd1, 5'd2, 5'd5, 1, 0);
        applyStimulus(0, 0, 0, 1, 5'd5, 5'd0, 5'd9, 1, 0);
        checkOutput("b2b_a", {30'd0, fwd_a_sel}, 32'd1);
        nop(); nop();

        // One-instruction gap -> 10
        applyStimulus(0, 0, 0, 1, 5'd1, 5'd2, 5'd5, 1, 0);
        nop();
        applyStimulus(0, 0, 0, 1, 5'd5, 5'd0, 5'd9, 1, 0);
        checkOutput("gap_a", {30'd0, fwd_a_sel}, 32'd2);
        nop(); nop();

        // rs2 match only
        applyStimulus(0, 0, 0, 1, 5'd1, 5'd2, 5'd5, 1, 0);
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd5, 5'd9, 1, 0);
        checkOutput("rs2_b", {30'd0, fwd_b_sel}, 32'd1);
        checkOutput("rs2_a", {30'd0, fwd_a_sel}, 32'd0);
        nop(); nop();

        // Youngest writer wins
        applyStimulus(0, 0, 0, 1, 5'd1, 5'd2, 5'd7, 1, 0);
        applyStimulus(0, 0, 0, 1, 5'd1, 5'd2, 5'd7, 1, 0);
        applyStimulus(0, 0, 0, 1, 5'd7, 5'd0, 5'd9, 1, 0);
        checkOutput("young_a", {30'd0, fwd_a_sel}, 32'd1);
        nop(); nop();

        // x0 writer that is a load: no stall, no forward
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd9, 1, 0);
        checkOutput("x0_stall", {31'd0, seen_stall}, 32'd0);
        checkOutput("x0_a", {30'd0, fwd_a_sel}, 32'd0);
        nop(); nop();

        // Hold three cycles during a pending load-use hazard
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd4, 1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 1, 5'd4, 5'd0, 5'd9, 1, 0);
            checkOutput("hold_stall_comb", {31'd0, seen_stall}, 32'd1);
            checkOutput("hold_cnt", ld_stall_cnt, 32'd1);
        end
        applyStimulus(0, 0, 0, 1, 5'd4, 5'd0, 5'd9, 1, 0);
        checkOutput("hold_resume_cnt", ld_stall_cnt, 32'd2);
        applyStimulus(0, 0, 0, 1, 5'd4, 5'd0, 5'd9, 1, 0);
        checkOutput("hold_resume_a", {30'd0, fwd_a_sel}, 32'd2);
        nop(); nop();

        // Flush during a load-use hazard
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd3, 1, 1);
        applyStimulus(0, 0, 1, 1, 5'd3, 5'd0, 5'd9, 1, 0);
        checkOutput("flush_stall", {31'd0, seen_stall}, 32'd0);
        checkOutput("flush_cnt", ld_stall_cnt, 32'd2);
        checkOutput("flush_a", {30'd0, fwd_a_sel}, 32'd0);
        applyStimulus(0, 0, 0, 1, 5'd3, 5'd0, 5'd9, 1, 0);
        checkOutput("flush_after_a", {30'd0, fwd_a_sel}, 32'd0);

        // Randomized traffic with small register range so hazards are frequent
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 10),
                          ($urandom_range(0, 99) < 8),
                          ($urandom_range(0, 99) < 85),
                          5'($urandom_range(0, 4)),
                          5'($urandom_range(0, 4)),
                          5'($urandom_range(0, 4)),
                          ($urandom_range(0, 99) < 75),
                          ($urandom_range(0, 99) < 35));
        end

        // Reset in the middle of a hazard clears everything
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd2, 1, 1);
        applyStimulus(1, 0, 0, 1, 5'd2, 5'd2, 5'd9, 1, 0);
        checkOutput("midrst_cnt", ld_stall_cnt, 32'd0);
        applyStimulus(0, 0, 0, 1, 5'd2, 5'd2, 5'd9, 1, 0);
        checkOutput("midrst_stall", {31'd0, seen_stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/fwd_ctrl.md
Name: fwd_ctrl

Overview:
- Forwarding and hazard controller for the integer pipeline (D -> X -> M -> W).
- Tracks the destination-register history of the in-flight instructions.
- Generates the registered 2-bit select codes that drive the X-stage operand forwarding muxes for rs1 and rs2. Codes: 00 = regfile, 01 = M-stage ALU result, 10 = W-stage writeback data.
- Detects load-use hazards and stalls D/F for exactly one cycle per hazard.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 32, width of the load-use stall counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- hold  in  1  global freeze (memory stall); all state holds
- flush  in  1  branch/jump redirect; kills the D and X instructions
- id_valid  in  1  D-stage instruction valid
- id_rs1  in  REG_AW  D-stage source 1 index
- id_rs2  in  REG_AW  D-stage source 2 index
- id_rd  in  REG_AW  D-stage destination index
- id_we  in  1  D-stage instruction writes rd
- id_is_load  in  1  D-stage instruction is a load
- fwd_a_sel  out  2  X-stage rs1 mux select (registered)
- fwd_b_sel  out  2  X-stage rs2 mux select (registered)
- ld_stall  out  1  hold F/D, inject bubble into X (combinational)
- ld_stall_cnt  out  CNT_W  count of load-use stall cycles

Behaviour:
- State: three stage entries X, M, W, each {valid, rd, we, load}.
- Producer condition: an entry is a producer only if valid && we && rd != 0.
- Reset (rst high at posedge): all entries invalid, fwd_a_sel = fwd_b_sel = 00, ld_stall_cnt = 0. ld_stall = 0 while all entries are invalid.
- Regfile is write-first. A W-stage producer is visible to a D-stage read, so no compare against W is needed at D.
- Selection is computed in D and registered into X, per source s in {rs1, rs2}:
  - X entry producer with rd == s and !load -> 01 (it is in M when the consumer is in X).
  - Otherwise, M entry producer with rd == s -> 10 (it is in W when the consumer is in X).
  - Otherwise -> 00.
  - The X match has priority over the M match (youngest producer wins).
  - s == 0 always yields 00.
- Load-use hazard:
  - ld_stall = id_valid && !flush && X producer && X.load && (X.rd == id_rs1 || X.rd == id_rs2).
  - The check uses both sources unconditionally; false stalls on unused sources are accepted.
- Update at posedge when !rst && !hold:
  - flush: X <= bubble; M <= bubble (the old X is killed); W <= old M; sel regs <= 00.
  - else ld_stall: X <= bubble; M <= X; W <= M; sel regs <= 00; ld_stall_cnt += 1 (wraps modulo 2^CNT_W).
  - else: X <= D (valid = id_valid); M <= X; W <= M; sel regs <= computed values.
- Stalled-consumer sequence:
  - After one stall cycle the load sits in M and the consumer is still in D.
  - The next cycle the consumer advances with sel = 10. Exactly one bubble is inserted.
- hold:
  - All registers keep their values, including sel and the counter.
  - ld_stall is still driven combinationally.
  - hold takes priority over flush and ld_stall.
- Priority: rst > hold > flush > ld_stall > normal.
- rst asserted mid-stall clears all state next edge; no pending stall survives reset.
- Invalid entries (bubbles) never match.

Decomposition:
- Shared package holds:
  - fwd_sel_t constants FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10.
  - Stage-entry struct {valid, rd, we, load}.
- One natural sub-module: fwd_sel_calc. It is combinational and, given a source index plus the X and M entries, returns the 2-bit select. It is instantiated twice, for rs1 and rs2.

Test Plan:
- Reset: hold rst 2 cycles -> sel a/b = 00, ld_stall = 0, ld_stall_cnt = 0.
- ALU back-to-back: add x5 in D, next cycle consumer rs1 = x5 -> fwd_a_sel = 01 during the consumer's X cycle. One instruction gap instead -> 10. rs2 = x5 with rs1 = x0 -> b = 01, a = 00.
- Youngest wins: x7 written by instructions i and i+1, consumer at i+2 reads x7 -> 01, not 10.
- Load-use: lw x3, then add rs2 = x3 -> ld_stall = 1 for exactly 1 cycle, bubble in X, then fwd_b_sel = 10, ld_stall_cnt = 1.
- x0 writer: addi x0 followed by consumer rs1 = x0 -> sel 00, no stall, even when the writer is a load.
- Flush/hold:
  - flush asserted during a load-use hazard -> ld_stall = 0, counter unchanged, sel 00 next cycle.
  - hold for 3 cycles mid-sequence -> sel and counter frozen; sequence resumes unchanged.
